// File: rtl/pipelined_adder_pkg.sv
// Shared constants and elaboration helpers for the chunked pipelined adder.
// The optional subtract mode is enabled by defining PIPE_ADDER_SUB_EN.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  typedef int unsigned stage_idx_t;

  // Bits handled by one pipeline stage.
  function automatic int chunk_w(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

  function automatic bit width_ok(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand and result channels of the pipelined adder.
// The sub field only exists when PIPE_ADDER_SUB_EN is defined.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // The producer holds valid and payload stable until that edge; ready may not depend on valid.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
`ifdef PIPE_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;

`ifdef PIPE_ADDER_SUB_EN
  modport master (
    output in_valid, A, B, Cin, sub, out_ready,
    input  in_ready, out_valid, S, Cout
  );
  modport slave (
    input  in_valid, A, B, Cin, sub, out_ready,
    output in_ready, out_valid, S, Cout
  );
`else
  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, S, Cout
  );
  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, S, Cout
  );
`endif

endinterface

// File: rtl/pipelined_adder_chunk.sv
// Combinational ripple-carry adder for one chunk of the pipelined adder.
module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic carry;

  always_comb begin
    carry = ci;
    s     = '0;
    for (int i = 0; i < W; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    co = carry;
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES chunks, one chunk added per clock with a registered carry.
// Defining PIPE_ADDER_SUB_EN adds a per-operation subtract mode (B inverted, Cin inverted).
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_adder_if.slave   bus
);

  localparam int CW = chunk_w(WIDTH, STAGES);

  if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic en;
  logic sub_eff;

  // Operand skew and sum de-skew registers shift right by one chunk per stage, so the
  // chunk a stage needs is always in the low bits and finished chunks enter at the top.
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [STAGES-1:0] c_in, v_in;

  logic [STAGES-1:0][CW-1:0] chunk_s;
  logic [STAGES-1:0]         chunk_co;

`ifdef PIPE_ADDER_SUB_EN
  assign sub_eff = bus.sub;
`else
  assign sub_eff = 1'b0;
`endif

  assign en            = !valid_q[STAGES-1] | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.S         = sum_q[STAGES-1];
  assign bus.Cout      = carry_q[STAGES-1];

  always_comb begin
    a_in[0] = bus.A;
    b_in[0] = bus.B ^ {WIDTH{sub_eff}};
    c_in[0] = bus.Cin ^ sub_eff;
    s_in[0] = '0;
    v_in[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = carry_q[k-1];
      s_in[k] = sum_q[k-1];
      v_in[k] = valid_q[k-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    adder_chunk #(.W(CW)) u_chunk (
      .a  (a_in[g][CW-1:0]),
      .b  (b_in[g][CW-1:0]),
      .ci (c_in[g]),
      .s  (chunk_s[g]),
      .co (chunk_co[g])
    );
  end

  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      sum_d[k] = sum_q[k];
      if (en) begin
        valid_d[k] = v_in[k];
        carry_d[k] = chunk_co[k];
        a_d[k]     = a_in[k] >> CW;
        b_d[k]     = b_in[k] >> CW;
        sum_d[k]   = s_in[k] >> CW;
        sum_d[k][WIDTH-CW +: CW] = chunk_s[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

endmodule
